// File: rtl/matrix_scan.sv
// Row/column scanner for a gs x gs key matrix; one row driven low at a time, debounced key-state frame out.
// Optional frame-to-frame debounce is built when MATRIX_SCAN_DEBOUNCE_EN is defined.
module matrix_scan #(
   parameter int gs     = 8,
   parameter int SETTLE = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             e_scan,
   input  logic [gs-1:0]    col_in_i,
   output logic [gs-1:0]    row_drv_o,
   output logic [gs*gs-1:0] matrix_o,
   output logic             d_scan_o,
   output logic             change_o
);

   localparam int RW = (gs > 1) ? $clog2(gs) : 1;
   localparam int CW = $clog2(SETTLE);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t           state_q, state_d;
   logic [RW-1:0]    row_q, row_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [gs-1:0]    col_s1, col_s2;
   logic [gs*gs-1:0] raw_q, raw_d, mat_d;
   logic             commit;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col_s1 <= '0;
         col_s2 <= '0;
      end else begin
         col_s1 <= col_in_i;
         col_s2 <= col_s1;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            row_d = '0;
            cnt_d = '0;
            if (e_scan) state_d = DRIVE;
         end
         DRIVE: begin
            if (!e_scan) begin
               state_d = IDLE;
               row_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == CW'(SETTLE - 1)) begin
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SAMPLE: begin
            cnt_d = '0;
            if (!e_scan) begin
               state_d = IDLE;
               row_d   = '0;
            end else if (row_q == RW'(gs - 1)) begin
               state_d = DONE;
               commit  = 1'b1;
            end else begin
               state_d = DRIVE;
               row_d   = row_q + 1'b1;
            end
         end
         DONE: begin
            row_d   = '0;
            cnt_d   = '0;
            state_d = e_scan ? DRIVE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Last row lands in raw on the same edge as the commit, so commit from raw_d.
   always_comb begin
      raw_d = raw_q;
      if (state_q == SAMPLE) begin
         for (int unsigned r = 0; r < gs; r++) begin
            if (row_q == RW'(r)) raw_d[gs*r +: gs] = ~col_s2;
         end
      end
   end

`ifdef MATRIX_SCAN_DEBOUNCE_EN
   logic [gs*gs-1:0] prev_q;
   logic [gs*gs-1:0] agree;

   assign agree = ~(raw_d ^ prev_q);
   assign mat_d = (raw_d & agree) | (matrix_o & ~agree);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       prev_q <= '0;
      else if (commit) prev_q <= raw_d;
   end
`else
   assign mat_d = raw_d;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         row_q    <= '0;
         cnt_q    <= '0;
         raw_q    <= '0;
         matrix_o <= '0;
         change_o <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         cnt_q    <= cnt_d;
         raw_q    <= raw_d;
         change_o <= commit && (mat_d != matrix_o);
         if (commit) matrix_o <= mat_d;
      end
   end

   always_comb begin
      row_drv_o = '1;
      if (state_q == DRIVE || state_q == SAMPLE) begin
         for (int unsigned r = 0; r < gs; r++) begin
            if (row_q == RW'(r)) row_drv_o[r] = 1'b0;
         end
      end
   end

   assign d_scan_o = (state_q == DONE);

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan: frame-level reference model plus directed key scenarios.
module tb_matrix_scan;

   localparam int GS = 8;
   localparam int ST = 4;
   localparam int RP = ST + 1;   // cycles per row
   localparam int P  = GS * RP;  // DONE cycle within a frame
`ifdef MATRIX_SCAN_DEBOUNCE_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             e_scan;
   logic [GS-1:0]    col_in;
   logic [GS-1:0]    row_drv;
   logic [GS*GS-1:0] matrix;
   logic             d_scan;
   logic             change;

   logic [GS*GS-1:0] keys;
   int               errors = 0;
   int               checks = 0;
   int               cyc    = 0;

   matrix_scan #(.gs(GS), .SETTLE(ST)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .e_scan   (e_scan),
      .col_in_i (col_in),
      .row_drv_o(row_drv),
      .matrix_o (matrix),
      .d_scan_o (d_scan),
      .change_o (change)
   );

   always #5 clk = ~clk;

   // Physical matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      col_in = '1;
      for (int r = 0; r < GS; r++)
         for (int c = 0; c < GS; c++)
            if (keys[GS*r + c] && !row_drv[r]) col_in[c] = 1'b0;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: frame position t, raw frame snapshot, committed matrix.
   bit               m_act  = 1'b0;
   int               m_t    = 0;
   bit               m_chg  = 1'b0;
   logic [GS*GS-1:0] m_raw  = '0;
   logic [GS*GS-1:0] m_prev = '0;
   logic [GS*GS-1:0] m_mat  = '0;

   always @(negedge clk) begin
      logic [GS-1:0]    exp_row;
      logic [GS*GS-1:0] agree, nxt;
      if (rst) begin
         m_act = 1'b0; m_t = 0; m_chg = 1'b0;
         m_raw = '0; m_prev = '0; m_mat = '0;
         chk("rst_row", 64'(row_drv), 64'hFF);
         chk("rst_matrix", matrix, 64'h0);
         chk("rst_dscan", 64'(d_scan), 64'h0);
         chk("rst_change", 64'(change), 64'h0);
      end else begin
         exp_row = '1;
         if (m_act && m_t != P) exp_row[m_t / RP] = 1'b0;
         chk("m_row", 64'(row_drv), 64'(exp_row));
         chk("m_dscan", 64'(d_scan), 64'(m_act && m_t == P));
         chk("m_change", 64'(change), 64'(m_act && m_t == P && m_chg));
         chk("m_matrix", matrix, m_mat);
         if (m_act && m_t < P && (m_t % RP) == ST)
            m_raw[GS*(m_t / RP) +: GS] = keys[GS*(m_t / RP) +: GS];
         if (!m_act) begin
            if (e_scan) begin m_act = 1'b1; m_t = 0; end
         end else if (m_t == P) begin
            if (e_scan) m_t = 0; else m_act = 1'b0;
         end else if (!e_scan) begin
            m_act = 1'b0;
         end else begin
            m_t++;
            if (m_t == P) begin
               if (DB) begin
                  agree = ~(m_raw ^ m_prev);
                  nxt   = (m_raw & agree) | (m_mat & ~agree);
               end else begin
                  nxt = m_raw;
               end
               m_prev = m_raw;
               m_chg  = (nxt != m_mat);
               m_mat  = nxt;
            end
         end
      end
   end

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         cyc++;
      end
      #1;
   endtask

   localparam logic [63:0] MK  = 64'h8000_0000_0800_0001;
   localparam logic [63:0] B21 = 64'h0000_0000_0020_0000;
   localparam logic [63:0] B56 = 64'h0100_0000_0000_0000;

   initial begin
      rst = 1'b1; e_scan = 1'b0; keys = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset mid-frame with key (1,1) held
      keys = 64'h200; e_scan = 1'b1;
      @(posedge clk); cyc = 0; #1;
      goto(17);
      chk("pre_rst_row", 64'(row_drv), 64'hF7);
      rst = 1'b1;
      #1;
      chk("async_rst_row", 64'(row_drv), 64'hFF);
      chk("async_rst_matrix", matrix, 64'h0);
      chk("async_rst_dscan", 64'(d_scan), 64'h0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; e_scan = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_row", 64'(row_drv), 64'hFF);
      chk("post_rst_matrix", matrix, 64'h0);
      chk("post_rst_dscan", 64'(d_scan), 64'h0);

      // Single key (2,5)
      keys = B21; e_scan = 1'b1;
      @(posedge clk); cyc = 0; #1;
      goto(9);  chk("row1_end", 64'(row_drv), 64'hFD);
      goto(10); chk("row2_start", 64'(row_drv), 64'hFB);
      goto(14); chk("row2_end", 64'(row_drv), 64'hFB);
      goto(15); chk("row3_start", 64'(row_drv), 64'hF7);
      goto(40);
      chk("done1_dscan", 64'(d_scan), 64'h1);
      chk("done1_row", 64'(row_drv), 64'hFF);
      chk("done1_b21", 64'(matrix[21]), 64'(!DB));
      chk("done1_change", 64'(change), 64'(!DB));
      goto(41);
      chk("f2_row0", 64'(row_drv), 64'hFE);
      chk("f2_dscan", 64'(d_scan), 64'h0);
      goto(81);
      chk("done2_dscan", 64'(d_scan), 64'h1);
      chk("done2_matrix", matrix, B21);
      chk("done2_change", 64'(change), 64'(DB));
      goto(122);
      chk("done3_change", 64'(change), 64'h0);

      // Glitch: key (7,0) for exactly one frame
      keys = B21 | B56;
      goto(163);
      chk("glitch_on_b56", 64'(matrix[56]), 64'(!DB));
      chk("glitch_on_change", 64'(change), 64'(!DB));
      keys = B21;
      goto(204);
      chk("glitch_off_b56", 64'(matrix[56]), 64'h0);
      chk("glitch_off_change", 64'(change), 64'(!DB));

      // Multi-key (0,0), (3,3), (7,7)
      keys = MK;
      goto(245);
      chk("multi1_matrix", matrix, DB ? B21 : MK);
      chk("multi1_change", 64'(change), 64'(!DB));
      goto(286);
      chk("multi2_matrix", matrix, MK);
      chk("multi2_change", 64'(change), 64'(DB));
      goto(327);
      chk("multi3_change", 64'(change), 64'h0);

      // Release all
      keys = '0;
      goto(368);
      chk("rel1_matrix", matrix, DB ? MK : 64'h0);
      chk("rel1_change", 64'(change), 64'(!DB));
      goto(409);
      chk("rel2_matrix", matrix, 64'h0);
      chk("rel2_change", 64'(change), 64'(DB));

      // Abort at cycle 20 of the next frame with key (0,0) held
      keys = 64'h1;
      goto(430);
      e_scan = 1'b0;
      goto(431);
      chk("abort_row", 64'(row_drv), 64'hFF);
      chk("abort_matrix", matrix, 64'h0);
      goto(480);
      chk("abort_late_dscan", 64'(d_scan), 64'h0);
      chk("abort_late_matrix", matrix, 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/matrix_scan.md
# matrix_scan

Row/column scanner for an 8x8 key/switch matrix: the input-side counterpart of the LED matrix display driver. It drives one row low at a time, samples the active-low column lines, and assembles a debounced `gs*gs` key-state frame. The frame uses the same bit layout the display driver consumes, so a captured frame can be routed straight back to the display.

## Interface
Parameters:
- `gs`, default 8: matrix size (rows = columns = `gs`).
- `SETTLE`, default 4, minimum 3: cycles a row is driven before its columns are sampled.

Ports:
- `clk_i`  input  1: single clock; all logic on rising edge.
- `rst_i`  input  1: reset, asynchronous and active-high.
- `e_scan`  input  1: scan enable; scanning runs continuously while high.
- `col_in_i`  input  `gs`: column lines, active-low (pressed key pulls its column low while its row is driven low), asynchronous to `clk_i`.
- `row_drv_o`  output  `gs`: row drive, active-low, at most one bit low at a time.
- `matrix_o`  output  `gs*gs`: key state; bit `gs*r + c` = 1 means key at row r, column c is pressed.
- `d_scan_o`  output  1: one-cycle pulse; frame complete, `matrix_o` updated.
- `change_o`  output  1: one-cycle pulse coincident with `d_scan_o` when any bit of `matrix_o` changed this frame.

## Operation
- `col_in_i` passes through a 2-flop synchronizer; only the synchronized value is sampled.
- State machine:
  - IDLE: `row_drv_o` all ones, counters 0. If `e_scan`=1, go to DRIVE with row=0, settle count=0.
  - DRIVE: `row_drv_o` = `~(1 << row)`. Settle count increments each cycle. At count = `SETTLE-1`, go to SAMPLE.
  - SAMPLE, one cycle, row still driven: raw[gs*row + c] <= ~col_sync[c]. If row = `gs-1`, go to DONE. Otherwise row+1, count=0, go to DRIVE.
  - DONE, one cycle: `row_drv_o` all ones, `d_scan_o`=1. Next state is DRIVE row 0 if `e_scan`=1, else IDLE.
- Frame commit happens on the edge entering DONE (see Configuration). `change_o` = (new `matrix_o` != old `matrix_o`), registered and visible during DONE.
- `e_scan` sampled low in DRIVE or SAMPLE: abort to IDLE on the next edge. The partial raw frame is discarded, and `matrix_o` and debounce history are unchanged. No `d_scan_o`.
- `e_scan` low in DONE: the frame still commits; then go to IDLE.
- Multiple simultaneous keys are reported as sampled. Ghosting suppression is out of scope and belongs to the consumer.

## Timing
- Reset values: `row_drv_o` all ones, `matrix_o` 0, `d_scan_o` 0, `change_o` 0, state IDLE. Raw frame, debounce history, and synchronizer are cleared to 0.
- Reset asserted mid-frame returns everything to reset values immediately, without waiting for a clock edge.
- Cycle 0 is the first DRIVE cycle, one cycle after `e_scan` is sampled high in IDLE.
  - Row r is driven during cycles r·(SETTLE+1) to r·(SETTLE+1)+SETTLE.
  - Row r is sampled in cycle r·(SETTLE+1)+SETTLE.
  - DONE falls in cycle gs·(SETTLE+1), which is cycle 40 for the defaults.
- Continuous scan: frame period is gs·(SETTLE+1)+1 cycles (41 for the defaults). Row 0 is driven again the cycle after DONE.
- Column settling: the pin value sampled was taken at least SETTLE−2 ≥ 1 cycles after its row went low.

## Configuration
- Macro `MATRIX_SCAN_DEBOUNCE_EN`.
- Defined:
  - An internal `gs*gs` history register `prev` holds the previous raw frame.
  - At commit, each bit k with raw[k] = prev[k] is loaded into `matrix_o[k]`. Bits that disagree hold their value.
  - `prev` <= raw.
  - A change is therefore reported no earlier than the second consecutive agreeing frame.
- Undefined: `matrix_o` <= raw at every commit; no history register is built.

## Test plan
- Reset: assert `rst_i` mid-frame with key (1,1) pressed. Required: `row_drv_o`=8'hFF, `matrix_o`=0, and `d_scan_o`=0 immediately, before any clock edge. After release with `e_scan`=0, outputs stay at these values.
- Single key (2,5) held, `e_scan`=1, defaults:
  - `row_drv_o`=8'hFB during cycles 10–14.
  - `d_scan_o` pulses at cycle 40 of each frame.
  - With debounce: bit 21 is set and `change_o`=1 at the second DONE (cycle 81). Without debounce: at the first DONE (cycle 40).
- Glitch, debounce build: key (7,0) pressed for exactly one frame. Required: bit 56 never set, `change_o` never asserted. Without debounce: bit 56 set for one frame, with `change_o` pulses at set and at clear.
- Abort: drop `e_scan` at cycle 20 with key (0,0) pressed. Required: `row_drv_o`=8'hFF from cycle 21, no `d_scan_o`, `matrix_o` unchanged.
- Multi-key: keys (0,0), (3,3), and (7,7) held. Required: `matrix_o` = 64'h8000_0000_0800_0001 after debounce, then `change_o`=0 on following frames.
- Release: release all keys from the multi-key state. Required: `matrix_o`=0 and one `change_o` pulse, after two frames with debounce, one frame without.
